// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and constants for the round-robin binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_NIBBLE_W = 4;
  localparam logic [3:0] BCD_BLANK    = 4'hF;

  // Largest value representable with the given number of decimal digits.
  function automatic int max_dec(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bus of the shared BCD converter: requests, operands and results.
interface bcd_conv_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*BIN_W-1:0] bin_in;
  logic [NREQ-1:0]       ack;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic [4*DIGITS-1:0]   dec_out;
  logic                  dec_valid;
  logic                  ovf;

  modport master (output req, bin_in,
                  input  ack, grant_id, busy, dec_out, dec_valid, ovf);
  modport slave  (input  req, bin_in,
                  output ack, grant_id, busy, dec_out, dec_valid, ovf);
endinterface

// File: rtl/bcd_conv_arbiter_dd_core.sv
// Double-dabble datapath: load an operand, then one add-3/shift step per enabled cycle.
module bcd_dd_core
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [BIN_W-1:0]               bin_load,
  input  logic                           step,
  output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd,
  output logic                           done
);
  localparam int             DW      = BCD_NIBBLE_W * DIGITS;
  localparam int             CW      = $clog2(BIN_W + 1);
  localparam logic [CW-1:0]  CNT_TOP = CW'(BIN_W - 1);

  logic [DW-1:0]    bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-2:0]    adj;
  logic [3:0]       nib;

  // The top nibble never exceeds 4 before the last shift, so its MSB is not kept.
  always_comb begin
    adj = '0;
    nib = '0;
    for (int d = 0; d < DIGITS - 1; d++) begin
      nib = bcd_q[d*BCD_NIBBLE_W +: BCD_NIBBLE_W];
      adj[d*BCD_NIBBLE_W +: BCD_NIBBLE_W] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    nib = bcd_q[DW-1 -: BCD_NIBBLE_W];
    adj[DW-2 -: 3] = (nib >= 4'd5) ? 3'(nib + 4'd3) : nib[2:0];
  end

  always_comb begin
    bcd_d = bcd_q;
    bin_d = bin_q;
    cnt_d = cnt_q;
    if (load) begin
      bcd_d = '0;
      bin_d = bin_load;
      cnt_d = CNT_TOP;
    end else if (step) begin
      {bcd_d, bin_d} = {adj, bin_q, 1'b0};
      cnt_d          = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else begin
      bcd_q <= bcd_d;
      bin_q <= bin_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd  = bcd_q;
  assign done = step && (cnt_q == '0);
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one double-dabble converter among NREQ requesters.
// Define BCD_LEADING_BLANK_EN to replace leading zero digits (above digit 0) with the blank code.
//   state | meaning
//   IDLE  | waiting; on any req pick the next requester after the pointer and load it
//   SHIFT | BIN_W add-3/shift steps of the captured operand
//   DONE  | publish dec_out/ovf and pulse ack/dec_valid for one cycle
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  bcd_conv_arbiter_if.slave bus
);
  localparam int               IDW     = $clog2(NREQ);
  localparam int               DW      = BCD_NIBBLE_W * DIGITS;
  localparam int               MAX_DEC = max_dec(DIGITS);
  localparam logic [BIN_W-1:0] MAX_BIN = MAX_DEC[BIN_W-1:0];

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, gid_q, gid_d;
  logic             busy_q, busy_d, dv_q, dv_d, ovf_q, ovf_d, clamp_q, clamp_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [DW-1:0]    dec_q, dec_d, dec_fmt, core_bcd;
  logic             found, load, core_done, clamp;
  logic [IDW-1:0]   win, cand;
  logic [BIN_W-1:0] raw_bin, op_bin;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign raw_bin = bus.bin_in[win*BIN_W +: BIN_W];
  assign clamp   = (raw_bin > MAX_BIN);
  assign op_bin  = clamp ? MAX_BIN : raw_bin;

`ifdef BCD_LEADING_BLANK_EN
  logic lead;
  always_comb begin
    dec_fmt = core_bcd;
    lead    = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (dec_fmt[d*BCD_NIBBLE_W +: BCD_NIBBLE_W] == 4'd0))
        dec_fmt[d*BCD_NIBBLE_W +: BCD_NIBBLE_W] = BCD_BLANK;
      else
        lead = 1'b0;
    end
  end
`else
  assign dec_fmt = core_bcd;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
    ack_d   = '0;
    dv_d    = 1'b0;
    dec_d   = dec_q;
    ovf_d   = ovf_q;
    clamp_d = clamp_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = win;
          ptr_d   = win;
          clamp_d = clamp;
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          busy_d = 1'b0;
        end
      end
      SHIFT: if (core_done) state_d = DONE;
      DONE: begin
        dec_d        = dec_fmt;
        ovf_d        = clamp_q;
        dv_d         = 1'b1;
        ack_d[gid_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      gid_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      dv_q    <= 1'b0;
      dec_q   <= '0;
      ovf_q   <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      dv_q    <= dv_d;
      dec_q   <= dec_d;
      ovf_q   <= ovf_d;
      clamp_q <= clamp_d;
    end
  end

  bcd_dd_core #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bin_load (op_bin),
    .step     (state_q == SHIFT),
    .bcd      (core_bcd),
    .done     (core_done)
  );

  assign bus.ack       = ack_q;
  assign bus.grant_id  = gid_q;
  assign bus.busy      = busy_q;
  assign bus.dec_out   = dec_q;
  assign bus.dec_valid = dv_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: directed scenarios, then random requesters.
module tb_bcd_conv_arbiter;
  localparam int NREQ   = 4;
  localparam int BIN_W  = 10;
  localparam int DIGITS = 3;
  localparam int DW     = 4 * DIGITS;
  localparam int LAT    = BIN_W + 2;
  localparam int MAXV   = 10**DIGITS - 1;

  typedef struct {
    int            id;
    logic [DW-1:0] dec;
    logic          ovf;
    int            t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;
  bit   strict = 1'b1;
  int   last_ack = -1000;
  int   cool [NREQ];
  exp_t sb[$];

  bcd_conv_arbiter_if #(.NREQ(NREQ), .BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_le(input string nm, input int act, input int lim);
    nvec++;
    if (act > lim) begin
      nfail++;
      $display("FAIL %s: got %0d, expected <= %0d (cycle %0d)", nm, act, lim, cyc);
    end
  endtask

  // Decimal digits by division; leading zeros above digit 0 are where value < 10**k.
  function automatic logic [DW-1:0] model(input int v);
    int c, p;
    logic [DW-1:0] r;
    c = (v > MAXV) ? MAXV : v;
    p = 1;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'((c / p) % 10);
`ifdef BCD_LEADING_BLANK_EN
      if (k > 0 && c < p) r[4*k +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  task automatic push(input int id, input int v);
    exp_t e;
    e.id  = id;
    e.dec = model(v);
    e.ovf = (v > MAXV);
    e.t   = cyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    int id, idx;
    exp_t e;
    if (!rst && (bus.dec_valid || bus.ack != '0)) begin
      chk("valid_with_ack", {31'd0, bus.dec_valid}, 32'd1);
      chk("ack_onehot", $countones(bus.ack), 32'd1);
      id = 0;
      for (int i = NREQ - 1; i >= 0; i--) if (bus.ack[i]) id = i;
      chk("grant_id", {30'd0, bus.grant_id}, id);
      nvec++;
      if (cyc - last_ack < LAT) begin
        nfail++;
        $display("FAIL ack_spacing: got %0d cycles, expected >= %0d", cyc - last_ack, LAT);
      end
      last_ack = cyc;
      idx = -1;
      if (strict) begin
        if (sb.size() > 0) idx = 0;
      end else begin
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].id == id) idx = i;
      end
      if (idx < 0) begin
        chk("spurious_ack", {28'd0, bus.ack}, 32'd0);
      end else begin
        e = sb[idx];
        sb.delete(idx);
        if (strict) chk("ack_owner", id, e.id);
        chk("dec_out", {20'd0, bus.dec_out}, {20'd0, e.dec});
        chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
        chk_le("service_wait", cyc - e.t, NREQ * LAT + LAT);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int id, output int c);
    c = -1;
    for (int n = 0; n < 4 * LAT * NREQ; n++) begin
      @(posedge clk); #1;
      if (bus.ack[id]) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("ack_timeout", {31'd0, bus.ack[id]}, 32'd1);
  endtask

  task automatic wait_any(output int c);
    c = -1;
    for (int n = 0; n < 4 * LAT * NREQ; n++) begin
      @(posedge clk); #1;
      if (bus.ack != '0) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("ack_timeout_any", {28'd0, bus.ack}, 32'd1);
  endtask

  task automatic single(input int id, input int v);
    int c0, c1;
    @(posedge clk); #1;
    bus.bin_in[id*BIN_W +: BIN_W] = v[BIN_W-1:0];
    bus.req[id] = 1'b1;
    push(id, v);
    c0 = cyc;
    wait_ack(id, c1);
    if (c1 >= 0) chk("latency", c1 - c0, LAT);
    chk("busy_in_ack_cycle", {31'd0, bus.busy}, 32'd1);
    bus.req[id] = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic held_round(input logic [NREQ-1:0] mask, input int nacks);
    int c0, c, prev;
    c0 = cyc;
    prev = -1;
    for (int k = 0; k < nacks; k++) begin
      wait_any(c);
      if (k == 0 && c >= 0) chk("first_latency", c - c0, LAT);
      if (prev >= 0 && c >= 0) chk("held_spacing", c - prev, LAT);
      prev = c;
    end
    bus.req = bus.req & ~mask;
  endtask

  initial begin
    int c0, v;
    bus.req    = '0;
    bus.bin_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {28'd0, bus.ack}, 32'd0);
    chk("rst_dec_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst_dec_out", {20'd0, bus.dec_out}, 32'd0);
    chk("rst_grant_id", {30'd0, bus.grant_id}, 32'd0);

    single(0, 255);
    single(2, 1000);
    single(2, 999);
    single(2, 0);
    single(3, 7);

    do_reset();
    @(posedge clk); #1;
    bus.bin_in[0*BIN_W +: BIN_W] = 10'd123;
    bus.bin_in[2*BIN_W +: BIN_W] = 10'd456;
    bus.req = 4'b0101;
    push(0, 123); push(2, 456); push(0, 123); push(2, 456);
    held_round(4'b0101, 4);

    do_reset();
    @(posedge clk); #1;
    bus.bin_in = {10'd808, 10'd1023, 10'd222, 10'd11};
    bus.req = 4'b1111;
    push(0, 11); push(1, 222); push(2, 1023); push(3, 808); push(0, 11);
    held_round(4'b1111, 5);

    @(posedge clk); #1;
    bus.bin_in[0 +: BIN_W] = 10'd512;
    bus.req[0] = 1'b1;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req = '0;
    chk("abort_dec_out", {20'd0, bus.dec_out}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_ack", {28'd0, bus.ack}, 32'd0);
    repeat (2 * LAT) @(posedge clk);
    single(0, 512);

    @(posedge clk); #1;
    bus.bin_in[1*BIN_W +: BIN_W] = 10'd37;
    bus.req[1] = 1'b1;
    push(1, 37);
    repeat (3) @(posedge clk);
    #1 bus.bin_in[1*BIN_W +: BIN_W] = 10'd800;
    wait_ack(1, c0);
    bus.req[1] = 1'b0;

    strict = 1'b0;
    for (int i = 0; i < NREQ; i++) cool[i] = $urandom_range(0, 8);
    for (int n = 0; n < 900; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i]) begin
          if (bus.ack[i]) begin
            bus.req[i] = 1'b0;
            cool[i] = $urandom_range(0, 20);
          end
        end else if (n < 780) begin
          v = $urandom_range(0, 1023);
          bus.bin_in[i*BIN_W +: BIN_W] = v[BIN_W-1:0];
          if (cool[i] == 0) begin
            push(i, v);
            bus.req[i] = 1'b1;
          end else begin
            cool[i]--;
          end
        end
      end
    end
    chk("drain_left", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one sequential binary-to-BCD (double-dabble) converter among NREQ requesters.
- Typical requesters: switch-selected counters and key-scan values feeding the TM1638 display path.
- Arbitrates round-robin, converts the granted binary operand to DIGITS packed BCD digits, and returns the result with a one-cycle ack to the winner.
- Sits between the value sources and the display-segment formatter; dec_out has the same packed layout the display path already consumes (digit 0 in [3:0]).

Parameters:
- NREQ, 4, number of requesters (2..8).
- BIN_W, 10, binary operand width; must satisfy 2**BIN_W > 10**DIGITS - 1.
- DIGITS, 3, BCD output digits; output width 4*DIGITS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester conversion request, level; held until ack.
- bin_in  in  NREQ*BIN_W  packed operands; requester i occupies [i*BIN_W +: BIN_W].
- ack  out  NREQ  one-hot, one-cycle pulse marking the result as belonging to requester i.
- grant_id  out  $clog2(NREQ)  index of the requester currently or last served.
- busy  out  1  high from load through DONE.
- dec_out  out  4*DIGITS  registered BCD result; holds until the next DONE.
- dec_valid  out  1  one-cycle pulse, coincident with ack.
- ovf  out  1  registered with dec_out; 1 if the operand was clamped.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ack=0, dec_valid=0, busy=0, ovf=0, dec_out=0, grant_id=0, round-robin pointer=NREQ-1 (requester 0 wins first).
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, any req bit set: select the first set bit searching from pointer+1 modulo NREQ. At that edge:
  - latch grant_id and update pointer to the winner;
  - capture bin_in[winner], clamped to 10**DIGITS-1, with the ovf flag latched if clamping occurred;
  - clear the BCD shift register; set busy=1; go to SHIFT.
- IDLE, no req: stay in IDLE; outputs hold.
- SHIFT lasts exactly BIN_W cycles. Each cycle:
  - add 3 to every BCD nibble >= 5;
  - then shift {bcd, bin} left by 1.
  - A cycle counter reaching BIN_W-1 moves the state to DONE.
- DONE entry edge: register dec_out and ovf; assert dec_valid=1 and ack[grant_id]=1 for exactly one cycle; next edge go to IDLE, busy=0.
- Latency: request sampled at edge E -> ack high during the cycle after edge E+BIN_W+1 (12 cycles with BIN_W=10). Minimum spacing between acks is BIN_W+2 cycles.
- Operand is captured at grant; later changes to bin_in do not affect the conversion in flight.
- req dropped mid-conversion: the conversion completes and ack/dec_valid still pulse; the requester ignores them. No abort.
- Winner still holding req in the DONE cycle: it is not re-granted if another req is set. Fairness comes from the pointer; a lone requester is re-granted on the IDLE edge after DONE.
- Simultaneous reqs: exactly one grant per round; the others wait. No starvation: a held request is served within NREQ rounds.
- rst during SHIFT or DONE: immediate return to the reset state; no ack is issued for the aborted conversion; dec_out=0.
- Arithmetic is unsigned; every nibble of dec_out is in 0..9, except the blank code below.

Optional Feature:
- Macro: BCD_LEADING_BLANK_EN.
- Defined: at DONE, leading zero digits above digit 0 are replaced by 4'hF (blank code for the segment decoder). Digit 0 is never blanked. Example: 7 -> 12'hFF7.
- Undefined: leading zeros are kept. Example: 7 -> 12'h007.

Decomposition:
- Package bcd_pkg:
  - state enum typedef (IDLE, SHIFT, DONE);
  - constants BCD_BLANK=4'hF and BCD_NIBBLE_W=4;
  - function max_dec(DIGITS) returning 10**DIGITS-1.
- Sub-module bcd_dd_core: the double-dabble datapath (load, add-3/shift step, done flag). The arbiter FSM and round-robin pointer stay in bcd_conv_arbiter.

Test Plan:
- req0=1, bin 255 -> after 12 cycles ack=4'b0001, dec_valid=1, dec_out=12'h255, ovf=0; busy falls the next cycle.
- req2=1, bin 1000 -> dec_out=12'h999, ovf=1; with bin 999 -> 12'h999, ovf=0; with bin 0 -> 12'h000 (12'hFF0 with BCD_LEADING_BLANK_EN).
- req0 and req2 asserted together and held, after reset -> ack order 0, 2, 0, 2; each ack spaced 12 cycles apart; grant_id tracks the winner.
- All four reqs held -> acks rotate 0, 1, 2, 3, 0; no requester is served twice before the others.
- rst=1 for one cycle six cycles into a conversion of 512 -> no ack; dec_out=0 and busy=0 after that edge; a new request for 512 then yields 12'h512.
- bin_in changed from 37 to 800 two cycles after grant -> result 12'h037 (12'hF37 with BCD_LEADING_BLANK_EN).
